minterm_sweep_ctrl: RTL and testbench

MINTERM_SWEEP_CTRL -- requirements
Module: minterm_sweep_ctrl

---
 rtl/minterm_sweep_ctrl.sv | 133 +++++++++++++
 tb/tb_minterm_sweep_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/minterm_sweep_ctrl.sv
// minterm_sweep_ctrl
// Walks a 4-input boolean function through all 16 input codes and captures
// its response into a truth table. The codes go in binary or Gray order.
// After the sweep, the captured table is compared with a golden table.
//
// Ports
//   clk, rst          single clock; synchronous active-high reset
//   start             launches a sweep; sampled only in IDLE
//   abort             ends a running sweep; no done pulse and no compare
//   gray_en           order select, latched with start (1 = Gray)
//   expected[15:0]    golden truth table, sampled in CHECK
//   func_in           response of the function under control
//   a, b, c, d        registered drive to the function ({a,b,c,d}, a = MSB)
//   busy              high in DRIVE, CHECK and DONE
//   done              one-cycle pulse while in DONE
//   truth_table[15:0] captured table; bit i = func_in seen while code = i
//                     (the name "table" is a reserved word in SystemVerilog)
//   mismatch[15:0]    truth_table ^ expected, registered in CHECK
//   pass              mismatch == 0, registered in CHECK
module minterm_sweep_ctrl #(
  parameter int SETTLE = 2  // cycles each code is held, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        gray_en,
  input  logic [15:0] expected,
  input  logic        func_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [15:0] mismatch,
  output logic        pass
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       gray_q, gray_nxt;
  logic       clr, cap, chk;
  logic [3:0] code_cur, code_nxt;

  function automatic logic [3:0] code_of(input logic [3:0] i, input logic g);
    return g ? (i ^ (i >> 1)) : i;
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    gray_nxt  = gray_q;
    clr       = 1'b0;
    cap       = 1'b0;
    chk       = 1'b0;
    case (state)
      IDLE: if (start && !abort) begin
        state_nxt = DRIVE;
        idx_nxt   = 4'd0;
        cnt_nxt   = 4'd0;
        gray_nxt  = gray_en;
        clr       = 1'b1;
      end
      DRIVE: begin
        // On abort, the capture in this cycle is dropped. The table then
        // holds only the codes that were fully settled.
        if (abort) state_nxt = IDLE;
        else if (cnt == LAST) begin
          cap = 1'b1;
          if (idx == 4'd15) state_nxt = CHECK;
          else begin
            idx_nxt = idx + 4'd1;
            cnt_nxt = 4'd0;
          end
        end else cnt_nxt = cnt + 4'd1;
      end
      CHECK: begin
        if (abort) state_nxt = IDLE;
        else begin
          chk       = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign code_cur = code_of(idx, gray_q);
  // The drive is registered from the next-state values, so {a,b,c,d} always
  // matches code(idx) while in DRIVE and is 0 in every other state.
  assign code_nxt = (state_nxt == DRIVE) ? code_of(idx_nxt, gray_nxt) : 4'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= 4'd0;
      cnt          <= 4'd0;
      gray_q       <= 1'b0;
      {a, b, c, d} <= 4'd0;
      truth_table  <= 16'd0;
      mismatch     <= 16'd0;
      pass         <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      cnt          <= cnt_nxt;
      gray_q       <= gray_nxt;
      {a, b, c, d} <= code_nxt;
      if (clr) begin
        truth_table <= 16'd0;
        mismatch    <= 16'd0;
        pass        <= 1'b0;
      end
      if (cap) truth_table[code_cur] <= func_in;
      if (chk) begin
        mismatch <= truth_table ^ expected;
        pass     <= ((truth_table ^ expected) == 16'd0);
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
module tb_minterm_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, gray_en;
  logic [15:0] expected;
  logic        func_in;
  logic        a, b, c, d, busy, done, pass;
  logic [15:0] truth_table, mismatch;
  logic [3:0]  code;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  assign code    = {a, b, c, d};
  assign func_in = ~d;

  minterm_sweep_ctrl #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .gray_en(gray_en),
    .expected(expected), .func_in(func_in),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done),
    .truth_table(truth_table), .mismatch(mismatch), .pass(pass)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge; on return the bench is in cycle 1 of the sweep.
  task automatic launch(input logic g);
    gray_en = g;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; gray_en = 1'b0; expected = 16'h5555;
    step(); step();
    n_tot++;
    if ({code, busy, done, pass, truth_table, mismatch} !== 39'd0)
      $display("FAIL reset: code=%h busy=%b done=%b pass=%b table=%h mm=%h want all 0",
               code, busy, done, pass, truth_table, mismatch);
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_binary();
    int bad;
    bad = 0;
    expected = 16'h5555;
    launch(1'b0);
    for (int k = 1; k <= 32; k++) begin
      if (code !== 4'((k - 1) / 2) || busy !== 1'b1 || done !== 1'b0) bad++;
      step();
    end
    n_tot++;
    if (bad != 0) $display("FAIL bin_seq: %0d bad cycles, want 0", bad); else n_pass++;
    n_tot++;
    if (done !== 1'b0 || busy !== 1'b1 || code !== 4'd0)
      $display("FAIL bin_check_cycle: done=%b busy=%b code=%h want 0/1/0", done, busy, code);
    else n_pass++;
    step();
    n_tot++;
    if (done !== 1'b1) $display("FAIL bin_done34: done=%b want 1", done); else n_pass++;
    n_tot++;
    if (truth_table !== 16'h5555 || mismatch !== 16'h0 || pass !== 1'b1)
      $display("FAIL bin_result: table=%h mm=%h pass=%b want 5555/0000/1",
               truth_table, mismatch, pass);
    else n_pass++;
    step();
    n_tot++;
    if (busy !== 1'b0 || done !== 1'b0 || truth_table !== 16'h5555 || pass !== 1'b1)
      $display("FAIL bin_hold: busy=%b done=%b table=%h pass=%b want 0/0/5555/1",
               busy, done, truth_table, pass);
    else n_pass++;
  endtask

  task automatic test_gray();
    logic [3:0] gseq [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                              4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    logic [3:0] prev;
    int bad, hops;
    bad = 0; hops = 0; prev = 4'd0;
    expected = 16'h5555;
    launch(1'b1);
    for (int k = 1; k <= 32; k++) begin
      if (code !== gseq[(k - 1) / 2]) bad++;
      if (k > 1 && code != prev && $countones(code ^ prev) != 1) hops++;
      prev = code;
      step();
    end
    n_tot++;
    if (bad != 0) $display("FAIL gray_seq: %0d bad cycles, want 0", bad); else n_pass++;
    n_tot++;
    if (hops != 0) $display("FAIL gray_onebit: %0d multi-bit steps, want 0", hops); else n_pass++;
    step();
    n_tot++;
    if (done !== 1'b1 || truth_table !== 16'h5555 || pass !== 1'b1)
      $display("FAIL gray_result: done=%b table=%h pass=%b want 1/5555/1",
               done, truth_table, pass);
    else n_pass++;
    step();
  endtask

  task automatic test_mismatch();
    int dones;
    dones = 0;
    expected = 16'h5554;
    launch(1'b0);
    for (int k = 1; k <= 40; k++) begin
      if (done === 1'b1) dones++;
      step();
    end
    n_tot++;
    if (dones != 1) $display("FAIL mm_done_once: %0d pulses want 1", dones); else n_pass++;
    n_tot++;
    if (mismatch !== 16'h0001 || pass !== 1'b0)
      $display("FAIL mm_result: mm=%h pass=%b want 0001/0", mismatch, pass);
    else n_pass++;
    expected = 16'h5555;
  endtask

  task automatic test_abort();
    int dones;
    dones = 0;
    launch(1'b0);
    for (int k = 1; k < 13; k++) step();
    n_tot++;
    if (code !== 4'd6) $display("FAIL abort_at6: code=%h want 6", code); else n_pass++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_tot++;
    if (busy !== 1'b0 || code !== 4'd0)
      $display("FAIL abort_idle: busy=%b code=%h want 0/0", busy, code);
    else n_pass++;
    n_tot++;
    if (truth_table !== 16'h0015)
      $display("FAIL abort_table: table=%h want 0015", truth_table);
    else n_pass++;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) dones++;
      step();
    end
    n_tot++;
    if (dones != 0) $display("FAIL abort_nodone: %0d pulses want 0", dones); else n_pass++;
    launch(1'b0);
    for (int k = 1; k < 34; k++) step();
    n_tot++;
    if (done !== 1'b1 || truth_table !== 16'h5555 || pass !== 1'b1)
      $display("FAIL abort_rerun: done=%b table=%h pass=%b want 1/5555/1",
               done, truth_table, pass);
    else n_pass++;
    step();
  endtask

  task automatic test_abort_start_idle();
    abort = 1'b1; start = 1'b1;
    step(); step();
    abort = 1'b0; start = 1'b0;
    n_tot++;
    if (busy !== 1'b0) $display("FAIL abort_prio: busy=%b want 0", busy); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    int dones, at;
    dones = 0; at = 0;
    launch(1'b0);
    for (int k = 1; k < 10; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tot++;
    if ({code, busy, done, pass, truth_table, mismatch} !== 39'd0)
      $display("FAIL midrst: code=%h busy=%b done=%b pass=%b table=%h mm=%h want all 0",
               code, busy, done, pass, truth_table, mismatch);
    else n_pass++;
    launch(1'b0);
    for (int k = 1; k <= 40; k++) begin
      start = (k == 5 || k == 20);
      if (done === 1'b1) begin dones++; at = k; end
      step();
    end
    start = 1'b0;
    n_tot++;
    if (dones != 1 || at != 34)
      $display("FAIL busy_start_ignored: pulses=%0d at=%0d want 1 at 34", dones, at);
    else n_pass++;
    // Held start: relaunch on the first IDLE cycle after DONE.
    launch(1'b0);
    start = 1'b1;
    for (int k = 2; k <= 35; k++) step();
    n_tot++;
    if (busy !== 1'b0) $display("FAIL hold_idle35: busy=%b want 0", busy); else n_pass++;
    step();
    start = 1'b0;
    n_tot++;
    if (busy !== 1'b1 || code !== 4'd0)
      $display("FAIL hold_relaunch: busy=%b code=%h want 1/0", busy, code);
    else n_pass++;
    for (int k = 0; k < 40; k++) step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; gray_en = 1'b0; expected = 16'h0;
    test_reset();
    test_binary();
    test_gray();
    test_mismatch();
    test_abort();
    test_abort_start_idle();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
